core_seq: RTL and testbench

Multi-cycle sequencer for the RV32 core. Owns the PC and the instruction register and fetches over a req/ack instruction-memory handshake. It steps each instruction through FETCH, DECODE, EXEC and WB, driving the register-file write strobe and writeback select from the decoder's outputs. It detects illegal opcodes, misaligned jump targets and fetch timeouts, and parks in a sticky TRAP state.

---
 rtl/core_seq.sv | 173 +++++++++++++++++
 tb/tb_core_seq.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32 core.
// It owns the PC and instruction register, fetches over a req/ack handshake,
// and parks in a sticky TRAP state on an illegal opcode, a misaligned jump
// target or a fetch timeout.
module core_seq #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic [6:0]  dec_opcode,
    input  logic        dec_we,
    input  logic        dec_writeback,
    input  logic [4:0]  dec_rd,
    input  logic [31:0] dec_imm,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [31:0] link_data,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_TRAP   = 3'd4
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        pending_q, pending_d;
    logic [1:0]  cause_q, cause_d;

    logic        is_jal;
    logic        op_legal;
    logic [31:0] jal_target;
    logic [31:0] tmo_inc;
    logic        timeout_hit;

    assign is_jal      = (dec_opcode == OP_JAL);
    assign op_legal    = (dec_opcode == OP_R) || (dec_opcode == OP_I) ||
                         (dec_opcode == OP_LUI) || (dec_opcode == OP_JAL);
    assign jal_target  = pc_q + dec_imm;
    assign tmo_inc     = tmo_cnt_q + 32'd1;
    assign timeout_hit = (FETCH_TIMEOUT != 0) && (tmo_inc == FETCH_TIMEOUT);

    // Handshake and writeback outputs; both strobes are forced low while reset is held.
    always_comb begin
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        if (rst_n && (state_q == ST_FETCH)) begin
            imem_req = run || pending_q;
        end
        if (rst_n && (state_q == ST_WB)) begin
            rf_we  = dec_we && (dec_rd != 5'd0);
            wb_sel = dec_writeback;
        end
        imem_addr  = pc_q;
        ir         = ir_q;
        link_data  = pc_q + 32'd4;
        pc         = pc_q;
        state      = state_q;
        instret    = instret_q;
        trap       = (state_q == ST_TRAP);
        trap_cause = cause_q;
    end

    // Next-state logic: step FETCH->DECODE->EXEC->WB, diverting to TRAP on faults.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        tmo_cnt_d = tmo_cnt_q;
        pending_d = pending_q;
        cause_d   = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_d      = imem_rdata;
                        pending_d = 1'b0;
                        tmo_cnt_d = 32'd0;
                        state_d   = ST_DECODE;
                    end else if (timeout_hit) begin
                        pending_d = 1'b0;
                        tmo_cnt_d = tmo_inc;
                        cause_d   = CAUSE_TIMEOUT;
                        state_d   = ST_TRAP;
                    end else begin
                        pending_d = 1'b1;
                        tmo_cnt_d = tmo_inc;
                    end
                end
            end
            ST_DECODE: begin
                if (!op_legal) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_jal && (jal_target[1:0] != 2'b00)) begin
                    cause_d = CAUSE_MISALIGN;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d      = is_jal ? jal_target : (pc_q + 32'd4);
                instret_d = instret_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Architectural and sequencing registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= NOP_INSN;
            instret_q <= 32'd0;
            tmo_cnt_q <= 32'd0;
            pending_q <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            tmo_cnt_q <= tmo_cnt_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: an instruction-level model walks a random
// (or preset) program and queues the expected retire/trap events; a monitor
// pops and compares them as the DUT reaches WB or enters TRAP.
module tb_core_seq;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          isTrap;
        logic [31:0] pc;
        logic [31:0] instret;
        logic        rfWe;
        logic        wbSel;
        logic [31:0] link;
        logic [1:0]  cause;
    } expEvent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic [6:0]  dec_opcode;
    logic        dec_we;
    logic        dec_writeback;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        rf_we;
    logic        wb_sel;
    logic [31:0] link_data;
    logic [31:0] pc;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    expEvent_t   expQ [$];

    int  ackDelay = 0;
    bit  holdAck = 1'b0;
    bit  spurious = 1'b0;
    int  waitCnt = 0;
    int  curDelay = 0;
    bit  trapSeen = 1'b0;

    int          modelRet;
    bit          modelTrap;
    logic [31:0] modelPc;

    always #5 clk = ~clk;

    core_seq #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .dec_opcode(dec_opcode), .dec_we(dec_we), .dec_writeback(dec_writeback),
        .dec_rd(dec_rd), .dec_imm(dec_imm), .rf_we(rf_we), .wb_sel(wb_sel),
        .link_data(link_data), .pc(pc), .state(state), .instret(instret),
        .trap(trap), .trap_cause(trap_cause)
    );

    function automatic bit isLegal(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h37) || (op == 7'h6F);
    endfunction

    function automatic logic [31:0] jImm(input logic [31:0] insn);
        return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] encJal(input logic [4:0] rd, input int off);
        logic [20:0] imm;
        imm = 21'(off);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] randomInstr(input int trapPct);
        logic [4:0]  rd;
        logic [6:0]  op;
        int          k;
        rd = 5'($urandom);
        k  = int'($urandom_range(0, 15)) - 8;
        if (int'($urandom_range(0, 99)) < trapPct) begin
            if ($urandom_range(0, 1) == 0) begin
                return encJal(rd, 4 * k + 2);
            end
            do op = 7'($urandom); while (isLegal(op));
            return {25'($urandom), op};
        end
        case ($urandom_range(0, 3))
            0: return {7'h00, 5'($urandom), 5'($urandom), 3'($urandom), rd, 7'h33};
            1: return {12'($urandom), 5'($urandom), 3'($urandom), rd, 7'h13};
            2: return {20'($urandom), rd, 7'h37};
            default: return encJal(rd, 4 * k);
        endcase
    endfunction

    // Instruction decoder stand-in: every legal class writes rd; JAL selects the link value.
    always_comb begin
        dec_opcode    = ir[6:0];
        dec_rd        = ir[11:7];
        dec_we        = isLegal(ir[6:0]);
        dec_writeback = (ir[6:0] == 7'h6F);
        case (ir[6:0])
            7'h6F:   dec_imm = jImm(ir);
            7'h13:   dec_imm = {{20{ir[31]}}, ir[31:20]};
            7'h37:   dec_imm = {ir[31:12], 12'h000};
            default: dec_imm = 32'd0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Walk the program at instruction level and queue the events the DUT should produce.
    task automatic buildTrace(input int maxRet, input int trapPct);
        logic [31:0] p, insn, tgt;
        expEvent_t   e;
        int          n;
        bit          done;
        p = 32'h0; n = 0; done = 1'b0; modelTrap = 1'b0;
        while (!done) begin
            if (!mem.exists(p)) mem[p] = randomInstr(trapPct);
            insn = mem[p];
            tgt  = p + jImm(insn);
            e = '{isTrap: 1'b0, pc: p, instret: 32'(n), rfWe: 1'b0, wbSel: 1'b0, link: p + 32'd4, cause: 2'b00};
            if (!isLegal(insn[6:0])) begin
                e.isTrap = 1'b1; e.cause = 2'b01; done = 1'b1;
            end else if ((insn[6:0] == 7'h6F) && (tgt[1:0] != 2'b00)) begin
                e.isTrap = 1'b1; e.cause = 2'b11; done = 1'b1;
            end else begin
                e.rfWe  = (insn[11:7] != 5'd0);
                e.wbSel = (insn[6:0] == 7'h6F);
                p = (insn[6:0] == 7'h6F) ? tgt : p + 32'd4;
                n++;
                if (n == maxRet) done = 1'b1;
            end
            if (e.isTrap) modelTrap = 1'b1;
            expQ.push_back(e);
        end
        modelRet = n;
        modelPc  = modelTrap ? e.pc : p;
    endtask

    // Hold reset for two cycles (run high to show the request stays low), check reset values, release.
    task automatic resetDut(input bit runAfter);
        rst_n = 1'b0;
        run   = 1'b1;
        waitCnt  = 0;
        curDelay = (ackDelay < 0) ? 0 : ackDelay;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instret", instret, 0);
        checkOutput("rst_trap", {trap, trap_cause}, 0);
        checkOutput("rst_ir", ir, NOP);
        rst_n = 1'b1;
        run   = runAfter;
    endtask

    // Run one program to completion, dropping run after the last modelled retirement.
    task automatic applyStimulus(input int maxRet, input int trapPct);
        int cyc;
        expQ.delete();
        buildTrace(maxRet, trapPct);
        resetDut(1'b1);
        cyc = 0;
        while (expQ.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!modelTrap && state == 3'd3 && instret == 32'(modelRet - 1)) run = 1'b0;
        end
        checkOutput("episode_drained", expQ.size(), 0);
        run = 1'b1;
        if (!modelTrap) run = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("episode_trap", trap, modelTrap);
        checkOutput("episode_pc", pc, modelPc);
        checkOutput("episode_instret", instret, 32'(modelRet));
        checkOutput("episode_req", imem_req, 0);
    endtask

    // Memory responder: acks after a programmed delay, sprinkles ignored acks when no request is up.
    always @(negedge clk) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req && !holdAck) begin
            if (waitCnt >= curDelay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : NOP;
                waitCnt    = 0;
                curDelay   = (ackDelay < 0) ? int'($urandom_range(0, 3)) : ackDelay;
            end else begin
                waitCnt++;
            end
        end else if (!imem_req) begin
            waitCnt = 0;
            if (spurious && $urandom_range(0, 3) == 0) imem_ack = 1'b1;
        end
    end

    // Scoreboard monitor: pop one event per WB cycle and one on TRAP entry.
    always @(negedge clk) begin
        expEvent_t e;
        if (!rst_n) begin
            trapSeen = 1'b0;
        end else begin
            if (state != 3'd3) checkOutput("rf_we_outside_wb", rf_we, 0);
            if (imem_req && expQ.size() != 0) checkOutput("imem_addr", imem_addr, expQ[0].pc);
            if (trap) checkOutput("req_in_trap", imem_req, 0);
            if (state == 3'd3 || (trap && !trapSeen)) begin
                if (trap) trapSeen = 1'b1;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_event: state %0d pc %h with empty queue", state, pc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event_is_trap", trap, e.isTrap);
                    checkOutput("event_pc", pc, e.pc);
                    checkOutput("event_instret", instret, e.instret);
                    if (e.isTrap) begin
                        checkOutput("trap_cause", trap_cause, e.cause);
                    end else begin
                        checkOutput("rf_we", rf_we, e.rfWe);
                        checkOutput("wb_sel", wb_sel, e.wbSel);
                        checkOutput("link_data", link_data, e.link);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        run   = 1'b0;

        // addi x1,x0,5 then NOP, immediate acks: four cycles each
        mem.delete();
        mem[32'h0] = 32'h0050_0093;
        mem[32'h4] = NOP;
        ackDelay = 0;
        expQ.delete();
        buildTrace(2, 0);
        resetDut(1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) checkOutput("t1_pc_first", pc, 32'h4);
            if (c == 7) run = 1'b0;
        end
        checkOutput("t1_instret", instret, 2);
        checkOutput("t1_pc", pc, 32'h8);
        checkOutput("t1_drained", expQ.size(), 0);

        // JAL chain: 0 -> 0x10, JAL x1,+8 at 0x10 -> 0x18
        mem.delete();
        mem[32'h0]  = 32'h0100_00EF;
        mem[32'h10] = 32'h0080_00EF;
        mem[32'h18] = NOP;
        ackDelay = -1;
        spurious = 1'b1;
        applyStimulus(3, 0);

        // Fetch timeout with the request held across a run drop
        mem.delete();
        holdAck = 1'b1;
        expQ.delete();
        resetDut(1'b1);
        expQ.push_back('{isTrap: 1'b1, pc: 32'h0, instret: 32'h0, rfWe: 1'b0, wbSel: 1'b0, link: 32'h4, cause: 2'b10});
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) run = 1'b0;
            if (c == 3) checkOutput("t3_req_held", {imem_req, imem_addr}, {1'b1, 32'h0});
            if (c == 15) checkOutput("t3_no_trap_yet", trap, 0);
        end
        checkOutput("t3_trap", trap, 1);
        checkOutput("t3_cause", trap_cause, 2'b10);
        checkOutput("t3_pc", pc, 32'h0);
        holdAck = 1'b0;
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3_sticky", {trap, imem_req}, {1'b1, 1'b0});
        checkOutput("t3_drained", expQ.size(), 0);

        // Ack on the 16th request cycle beats the timeout
        mem.delete();
        mem[32'h0] = NOP;
        ackDelay = 15;
        applyStimulus(1, 0);
        ackDelay = -1;

        // Illegal opcode at 0x8, then acks keep arriving but are ignored
        mem.delete();
        mem[32'h0] = NOP;
        mem[32'h4] = NOP;
        mem[32'h8] = 32'h0000_0003;
        applyStimulus(5, 0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t4_ir_frozen", ir, 32'h0000_0003);
        checkOutput("t4_cause", trap_cause, 2'b01);
        checkOutput("t4_pc", pc, 32'h8);

        // JAL +6 traps misaligned; addi x0,x0,1 retires without a write
        mem.delete();
        mem[32'h0] = 32'h0060_00EF;
        applyStimulus(1, 0);
        checkOutput("t5_cause", trap_cause, 2'b11);
        mem.delete();
        mem[32'h0] = 32'h0010_0013;
        applyStimulus(1, 0);

        // Reset asserted in EXEC of the second instruction
        mem.delete();
        expQ.delete();
        buildTrace(6, 0);
        resetDut(1'b1);
        cyc = 0;
        while (!(state == 3'd2 && instret == 32'd1) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("t6_reached_exec", {state, instret}, {3'd2, 32'd1});
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_state", state, 0);
        checkOutput("t6_async_pc_instret", {pc, instret}, 64'h0);
        checkOutput("t6_async_strobes", {imem_req, rf_we}, 0);
        applyStimulus(6, 0);

        // Reset asserted mid-FETCH with the request up
        mem.delete();
        holdAck = 1'b1;
        expQ.delete();
        resetDut(1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t7_req_up", imem_req, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_req_dropped", imem_req, 0);
        checkOutput("t7_state_pc", {state, pc}, {3'd0, 32'h0});
        holdAck = 1'b0;
        applyStimulus(3, 0);

        // Random programs with occasional faults
        for (int ep = 0; ep < 4; ep++) begin
            mem.delete();
            applyStimulus(20, 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
